// File: rtl/mul_pkg.sv
// Shared multiplier constants and accumulator FSM states.
package mul_pkg;

  localparam int MUL_OP_W    = 16;
  localparam int MUL_PROD_W  = 32;
  localparam int MUL_LATENCY = 2;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int acc_min_w(input int vec_len);
    return MUL_PROD_W + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/mul_reg_top.sv
// Registered 16x16 unsigned multiplier.
// Operands sampled every edge; product appears two edges later.
module mul_reg_top
  import mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MUL_OP_W-1:0]   a_i,
  input  logic [MUL_OP_W-1:0]   b_i,
  output logic [MUL_PROD_W-1:0] p_o
);

  logic [MUL_OP_W-1:0]   a_q;
  logic [MUL_OP_W-1:0]   b_q;
  logic [MUL_PROD_W-1:0] p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      p_q <= MUL_PROD_W'(a_q) * MUL_PROD_W'(b_q);
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/mul_dot_acc.sv
// Dot-product accumulator: sums VEC_LEN products from mul_reg_top
// and holds each result on a valid/ready output until consumed.
module mul_dot_acc
  import mul_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_a,
  input  logic [MUL_OP_W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum
);

  if (VEC_LEN < 2 || VEC_LEN > 256) begin : g_bad_len
    $error("mul_dot_acc: VEC_LEN must be in 2..256");
  end
  if (ACC_W < acc_min_w(VEC_LEN)) begin : g_bad_w
    $error("mul_dot_acc: ACC_W too narrow for VEC_LEN products");
  end

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int VP    = MUL_LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [MUL_LATENCY-1:0] vld_q;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_d;
  logic                   out_valid_q;
  logic [ACC_W-1:0]       out_sum_q;
  logic [MUL_PROD_W-1:0]  prod;

  logic accept;
  logic out_hs;
  logic drain_done;

  mul_reg_top u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (in_a),
    .b_i   (in_b),
    .p_o   (prod)
  );

  assign in_ready   = (state_q == ACCUM) && (cnt_q < CNT_MAX);
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid_q && out_ready;
  // Last product lands when only the oldest pipe slot is occupied.
  assign drain_done = vld_q[VP] && !(|vld_q[VP-1:0]);

  always_comb begin
    acc_d = acc_q;
    if (out_hs) begin
      acc_d = '0;
    end else if (vld_q[VP]) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      vld_q <= {vld_q[VP-1:0], accept};
      acc_q <= acc_d;
      unique case (1'b1)
        state_q == ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= DRAIN;
            end
          end
        end
        state_q == DRAIN: begin
          if (drain_done) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_d;
          end
        end
        state_q == HOLD: begin
          if (out_hs) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_mul_dot_acc.sv
// Bench for mul_dot_acc: table vectors, corner sequences and a
// random stream checked against a cycle-level behavioural model.
module tb_mul_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv4 = 1'b0, or4 = 1'b0, ir4, ov4;
  logic [15:0] a4 = '0, b4 = '0;
  logic [39:0] os4;

  logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8;
  logic [15:0] a8 = '0, b8 = '0;
  logic [39:0] os8;

  always #5 clk = ~clk;

  mul_dot_acc #(.VEC_LEN(4), .ACC_W(40)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .in_a(a4), .in_b(b4),
    .out_valid(ov4), .out_ready(or4),
    .out_sum(os4)
  );

  mul_dot_acc #(.VEC_LEN(8), .ACC_W(40)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8),
    .out_sum(os8)
  );

  typedef struct {
    string       name;
    logic [15:0] a[4];
    logic [15:0] b[4];
    longint      exp;
  } vec_t;

  vec_t tbl[4];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Behavioural model of the VEC_LEN=4 instance.
  int     m_cnt  = 0;
  bit     m_full = 1'b0;
  int     m_k    = 0;
  longint m_sum  = 0;

  int     p_t[$];
  longint p_v[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_full = 1'b0;
    m_k    = 0;
    m_sum  = 0;
  endtask

  // One clock: note handshakes, advance, update model, compare.
  task automatic cyc();
    logic        acc, hs;
    logic [15:0] pa, pb;
    bit          e_ov;
    acc = iv4 && ir4;
    hs  = ov4 && or4;
    pa  = a4;
    pb  = b4;
    @(posedge clk);
    #1;
    cyc_n++;
    if (hs) model_reset();
    if (acc) begin
      m_sum += longint'(pa) * longint'(pb);
      m_cnt++;
      if (m_cnt == 4) begin
        m_full = 1'b1;
        m_k    = 0;
      end
    end else if (m_full) begin
      m_k++;
    end
    e_ov = m_full && (m_k >= 2);
    chk("in_ready", 64'(ir4), 64'(!m_full));
    chk("out_valid", 64'(ov4), 64'(e_ov));
    chk("out_sum", 64'(os4), e_ov ? 64'(m_sum) : 64'd0);
    if (ov4) begin
      p_t.push_back(cyc_n);
      p_v.push_back(longint'(os4));
    end
  endtask

  task automatic send4(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    a4  = a;
    b4  = b;
    iv4 = 1'b1;
    while (!ir4 && n < 50) begin
      cyc();
      n++;
    end
    if (!ir4) chk("send_timeout", 64'd0, 64'd1);
    cyc();
    iv4 = 1'b0;
  endtask

  task automatic send_tbl(input int k);
    for (int i = 0; i < 4; i++) send4(tbl[k].a[i], tbl[k].b[i]);
  endtask

  task automatic wait_ov4();
    int n = 0;
    while (!ov4 && n < 20) begin
      cyc();
      n++;
    end
    if (!ov4) chk("wait_out_valid", 64'd0, 64'd1);
  endtask

  task automatic do_reset(input int n);
    #2;
    rst_n = 1'b0;
    iv4   = 1'b0;
    iv8   = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("rst_out_valid", 64'(ov4), 64'd0);
      chk("rst_out_sum", 64'(os4), 64'd0);
      chk("rst_in_ready", 64'(ir4), 64'd1);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int     c_l;
    int     n_acc;
    bit     got;
    logic   acc, hs;

    tbl[0].name = "seq";
    tbl[0].a = '{16'd1, 16'd2, 16'd3, 16'd4};
    tbl[0].b = '{16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].exp = 70;
    tbl[1].name = "max";
    tbl[1].a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].b = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].exp = 64'd17179344900;
    tbl[2].name = "zero";
    tbl[2].a = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].b = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].exp = 0;
    tbl[3].name = "two_three";
    tbl[3].a = '{16'd2, 16'd2, 16'd2, 16'd2};
    tbl[3].b = '{16'd3, 16'd3, 16'd3, 16'd3};
    tbl[3].exp = 24;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid4", 64'(ov4), 64'd0);
    chk("reset_out_sum4", 64'(os4), 64'd0);
    chk("reset_in_ready4", 64'(ir4), 64'd1);
    chk("reset_out_valid8", 64'(ov8), 64'd0);
    rst_n = 1'b1;
    model_reset();
    cyc();

    // Table vectors, back-to-back, output always ready.
    or4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_tbl(k);
      c_l = cyc_n;
      wait_ov4();
      chk({"tbl_latency_", tbl[k].name}, 64'(cyc_n - c_l), 64'd2);
      chk({"tbl_sum_", tbl[k].name}, 64'(os4), 64'(tbl[k].exp));
      cyc();
      chk({"tbl_pulse_", tbl[k].name}, 64'(ov4), 64'd0);
      chk({"tbl_restart_", tbl[k].name}, 64'(ir4), 64'd1);
    end

    // Back-pressure: result held, input refused while stalled.
    or4 = 1'b0;
    send_tbl(0);
    wait_ov4();
    for (int i = 0; i < 10; i++) begin
      iv4 = 1'b1;
      a4  = 16'hAAAA;
      b4  = 16'h5555;
      chk("stall_out_valid", 64'(ov4), 64'd1);
      chk("stall_out_sum", 64'(os4), 64'd70);
      chk("stall_in_ready", 64'(ir4), 64'd0);
      cyc();
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    cyc();
    chk("stall_release_valid", 64'(ov4), 64'd0);
    chk("stall_release_ready", 64'(ir4), 64'd1);
    send_tbl(0);
    wait_ov4();
    chk("stall_next_sum", 64'(os4), 64'd70);
    cyc();

    // Abort a half-filled vector with reset.
    send4(16'd100, 16'd100);
    send4(16'd100, 16'd100);
    do_reset(3);
    send_tbl(3);
    wait_ov4();
    chk("abort_sum", 64'(os4), 64'd24);
    cyc();

    // Three vectors back-to-back: pulses VEC_LEN+3 apart.
    p_t.delete();
    p_v.delete();
    send_tbl(0);
    send_tbl(2);
    send_tbl(0);
    wait_ov4();
    repeat (3) cyc();
    chk("b2b_pulses", 64'(p_t.size()), 64'd3);
    if (p_t.size() == 3) begin
      chk("b2b_sum0", 64'(p_v[0]), 64'd70);
      chk("b2b_sum1", 64'(p_v[1]), 64'd0);
      chk("b2b_sum2", 64'(p_v[2]), 64'd70);
      chk("b2b_gap0", 64'(p_t[1] - p_t[0]), 64'd7);
      chk("b2b_gap1", 64'(p_t[2] - p_t[1]), 64'd7);
    end

    // VEC_LEN=8 with random input bubbles.
    or8   = 1'b1;
    n_acc = 0;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (n_acc < 8 && !iv8) begin
        iv8 = 1'($urandom_range(0, 1));
        a8  = 16'(n_acc + 1);
        b8  = 16'd2;
      end
      if (n_acc == 8) begin
        iv8 = 1'b1;
        a8  = 16'd99;
        chk("v8_in_ready_low", 64'(ir8), 64'd0);
      end
      acc = iv8 && ir8;
      hs  = ov8 && or8;
      if (hs) begin
        chk("v8_sum", 64'(os8), 64'd72);
        chk("v8_accepts", 64'(n_acc), 64'd8);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc && !got) begin
        n_acc++;
        iv8 = 1'b0;
      end
    end
    if (!got) chk("v8_timeout", 64'd0, 64'd1);
    iv8 = 1'b0;
    or8 = 1'b0;

    // Random stream on VEC_LEN=4 against the model.
    for (int c = 0; c < 800; c++) begin
      if (!iv4) begin
        iv4 = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          a4 = 16'hFFFF - 16'($urandom_range(0, 3));
          b4 = 16'hFFFF;
        end else begin
          a4 = 16'($urandom);
          b4 = 16'($urandom);
        end
      end
      or4 = 1'($urandom_range(0, 1));
      acc = iv4 && ir4;
      cyc();
      if (acc) iv4 = 1'b0;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    repeat (8) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
